// File: rtl/cmd_uart_if.sv
// ============================================================================
// Module  : cmd_uart_if
// Brief   : 8N1 UART command front end. Builds 16-bit commands from RX byte
//           pairs and transmits a one-byte acknowledge on request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_uart_if #(
  parameter int         BAUD_DIV  = 2604,
  parameter logic [7:0] RESP_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam logic [11:0] DIV_M1  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_M1 = 12'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic A_HIGH = 1'b0;
  localparam logic A_LOW  = 1'b1;

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_START = 2'd1;
  localparam logic [1:0] T_DATA  = 2'd2;
  localparam logic [1:0] T_STOP  = 2'd3;

  // ---------------- RX synchronizer and edge detect ----------------
  logic rx_s1, rx_s2, rx_d;
  logic rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall = rx_d & ~rx_s2;

  // ---------------- RX FSM ----------------
  logic [1:0]  r_state, r_next;
  logic [11:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_tick;
  logic        r_begin, r_data_smp, r_stop_smp;
  logic        byte_valid;
  logic [7:0]  byte_data;

  assign r_tick = (r_cnt == 12'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rx_fall) r_next = R_START;
      R_START: if (r_tick) r_next = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (r_tick && r_idx == 3'd7) r_next = R_STOP;
      R_STOP:  if (r_tick) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    r_begin    = (r_state == R_IDLE) && rx_fall;
    r_data_smp = (r_state == R_DATA) && r_tick;
    r_stop_smp = (r_state == R_STOP) && r_tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 12'd0;
      r_idx      <= 3'd0;
      r_shift    <= 8'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      frm_err    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frm_err    <= 1'b0;
      // Half-bit first so every later sample lands mid-bit.
      if (r_begin)
        r_cnt <= HALF_M1;
      else if (r_state != R_IDLE)
        r_cnt <= r_tick ? DIV_M1 : r_cnt - 12'd1;
      if (r_state == R_START)
        r_idx <= 3'd0;
      if (r_data_smp) begin
        r_shift <= {rx_s2, r_shift[7:1]};
        r_idx   <= r_idx + 3'd1;
      end
      if (r_stop_smp) begin
        if (rx_s2) begin
          byte_valid <= 1'b1;
          byte_data  <= r_shift;
        end else begin
          frm_err <= 1'b1;
        end
      end
    end
  end

  // ---------------- Command assembly FSM ----------------
  logic       a_state, a_next;
  logic [7:0] hold_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) a_state <= A_HIGH;
    else     a_state <= a_next;
  end

  always_comb begin
    a_next = a_state;
    if (frm_err)
      a_next = A_HIGH;
    else if (byte_valid)
      a_next = (a_state == A_HIGH) ? A_LOW : A_HIGH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_hi <= 8'd0;
      cmd     <= 16'd0;
      cmd_rdy <= 1'b0;
    end else begin
      if (byte_valid && a_state == A_HIGH)
        hold_hi <= byte_data;
      if (byte_valid && a_state == A_LOW)
        cmd <= {hold_hi, byte_data};
      // Completion has priority; a fresh high byte withdraws a stale command.
      if (byte_valid && a_state == A_LOW)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (byte_valid && a_state == A_HIGH))
        cmd_rdy <= 1'b0;
    end
  end

  // ---------------- TX FSM ----------------
  logic [1:0]  t_state, t_next;
  logic [11:0] t_cnt;
  logic [2:0]  t_idx;
  logic        t_tick;

  assign t_tick = (t_cnt == 12'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) t_state <= T_IDLE;
    else     t_state <= t_next;
  end

  always_comb begin
    t_next = t_state;
    case (t_state)
      T_IDLE:  if (send_resp) t_next = T_START;
      T_START: if (t_tick) t_next = T_DATA;
      T_DATA:  if (t_tick && t_idx == 3'd7) t_next = T_STOP;
      T_STOP:  if (t_tick) t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  always_comb begin
    TX      = 1'b1;
    tx_busy = (t_state != T_IDLE);
    case (t_state)
      T_START: TX = 1'b0;
      T_DATA:  TX = RESP_BYTE[t_idx];
      default: TX = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_cnt     <= 12'd0;
      t_idx     <= 3'd0;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= (t_state == T_STOP) && t_tick;
      if (t_state == T_IDLE) begin
        t_cnt <= DIV_M1;
        t_idx <= 3'd0;
      end else begin
        t_cnt <= t_tick ? DIV_M1 : t_cnt - 12'd1;
        if (t_state == T_DATA && t_tick)
          t_idx <= t_idx + 3'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_uart_if.sv
// ============================================================================
// Module  : tb_cmd_uart_if
// Brief   : Randomized self-checking bench for cmd_uart_if with a byte-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_uart_if;

  localparam int         BD   = 16;
  localparam logic [7:0] RESP = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        tx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;
  logic        frm_err;

  always #5 clk = ~clk;

  cmd_uart_if #(.BAUD_DIV(BD), .RESP_BYTE(RESP)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (rx),
    .TX         (tx),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp  (send_resp),
    .tx_busy    (tx_busy),
    .resp_sent  (resp_sent),
    .frm_err    (frm_err)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int frm_cnt = 0;
  int resp_cnt = 0;

  always @(posedge clk) begin
    if (frm_err)   frm_cnt++;
    if (resp_sent) resp_cnt++;
  end

  // Byte-level reference: pairs of good bytes form commands.
  logic [15:0] m_cmd;
  logic        m_rdy;
  logic        m_have_hi;
  logic [7:0]  m_hi;
  int          m_frm = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cmd = 16'd0; m_rdy = 1'b0; m_have_hi = 1'b0; m_hi = 8'd0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_have_hi = 1'b0;
      m_frm++;
    end else if (!m_have_hi) begin
      m_hi = b; m_have_hi = 1'b1; m_rdy = 1'b0;
    end else begin
      m_cmd = {m_hi, b}; m_rdy = 1'b1; m_have_hi = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cmd"}, 32'(cmd), 32'(m_cmd));
    chk({tag, "_rdy"}, 32'(cmd_rdy), 32'(m_rdy));
    chk({tag, "_frm"}, 32'(frm_cnt), 32'(m_frm));
  endtask

  // Drives one 8N1 frame. With clr_at_done, clr_cmd_rdy is held through the
  // completion edge and dropped once cmd_rdy is seen high.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit clr_at_done);
    logic [9:0] frame;
    bit completing, got;
    frame = {stop_ok, b, 1'b0};
    completing = stop_ok && m_have_hi;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      if (i == 9 && completing) chk("rdy_early", 32'(cmd_rdy), 32'd0);
      if (i == 9 && clr_at_done && completing) clr_cmd_rdy = 1'b1;
      repeat (BD) begin
        @(negedge clk);
        if (clr_cmd_rdy && cmd_rdy) begin clr_cmd_rdy = 1'b0; got = 1'b1; end
      end
    end
    rx = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (clr_cmd_rdy && cmd_rdy) begin clr_cmd_rdy = 1'b0; got = 1'b1; end
    end
    if (clr_at_done && completing) begin
      clr_cmd_rdy = 1'b0;
      chk("set_wins", 32'(got), 32'd1);
    end
    model_byte(b, stop_ok);
    check_state("byte");
  endtask

  task automatic clr_pulse();
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    chk("clr_rdy", 32'(cmd_rdy), 32'(m_rdy));
    chk("clr_cmd", 32'(cmd), 32'(m_cmd));
  endtask

  initial begin
    logic [9:0] txf;
    bit seen;
    int r0;
    rst = 1'b1; rx = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_resp", 32'(resp_sent), 32'd0);
    chk("rst_ferr", 32'(frm_err), 32'd0);
    check_state("rst");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame, with a high byte already pending.
    send_byte(8'h11, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (3 * BD) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    model_reset();
    chk("midrst_tx", 32'(tx), 32'd1);
    check_state("midrst");
    rst = 1'b0;
    repeat (2 * BD) @(negedge clk);
    send_byte(8'h2F, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);

    send_byte(8'h40, 1'b1, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    clr_pulse();

    // Unconsumed command withdrawn by a new high byte.
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);

    // Bad stop bit on the low byte.
    clr_pulse();
    send_byte(8'h77, 1'b1, 1'b0);
    send_byte(8'h88, 1'b0, 1'b0);
    send_byte(8'h60, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);

    // Acknowledge frame; a second request mid-frame must be ignored.
    r0 = resp_cnt;
    txf = {1'b1, RESP, 1'b0};
    @(negedge clk) send_resp = 1'b1;
    @(negedge clk) send_resp = 1'b0;
    chk("tx_busy_up", 32'(tx_busy), 32'd1);
    repeat (BD / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("tx_bit%0d", k), 32'(tx), 32'(txf[k]));
      if (k == 3) begin
        send_resp = 1'b1;
        @(negedge clk) send_resp = 1'b0;
        repeat (BD - 1) @(negedge clk);
      end else if (k < 9) begin
        repeat (BD) @(negedge clk);
      end
    end
    seen = 1'b0;
    for (int w = 0; w < 3 * BD && !seen; w++) begin
      @(negedge clk);
      if (resp_sent) begin
        seen = 1'b1;
        chk("busy_drop", 32'(tx_busy), 32'd0);
      end
    end
    chk("resp_seen", 32'(seen), 32'd1);
    repeat (14 * BD) @(negedge clk);
    chk("resp_once", 32'(resp_cnt - r0), 32'd1);
    chk("tx_idle", 32'(tx), 32'd1);

    // One-clock glitch, then completion coinciding with clr_cmd_rdy.
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (3 * BD) @(negedge clk);
    check_state("glitch");
    send_byte(8'hC3, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("set_wins_hold", 32'(cmd_rdy), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      bit ok, cl;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      cl = ok && m_have_hi && ($urandom_range(0, 3) == 0);
      send_byte(b, ok, cl);
      if (m_rdy && $urandom_range(0, 2) == 0) clr_pulse();
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (2 * BD) @(negedge clk);
        check_state("rglitch");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
